// File: rtl/pcie_us_rq_seq_num_merge_pkg.sv
// Shared helpers for the RQ sequence-number merge block.
package pcie_us_rq_seq_num_merge_pkg;

  // Bits needed to hold a count of 0..ports valid lanes.
  function automatic int unsigned lane_width(input int unsigned ports);
    return (ports < 2) ? 1 : $clog2(ports + 1);
  endfunction

endpackage

// File: rtl/pcie_us_rq_seq_num_compact.sv
// Packs the valid report ports into dense write slots (lowest port first)
// and limits how many are accepted to the free space in the buffer.
module pcie_us_rq_seq_num_compact
  import pcie_us_rq_seq_num_merge_pkg::*;
#(
  parameter int SEQ_NUM_WIDTH = 6,
  parameter int PORTS         = 2,
  parameter int CNT_W         = 5,
  localparam int LANE_W       = lane_width(PORTS)
) (
  input  logic [PORTS-1:0]               valid,
  input  logic [PORTS*SEQ_NUM_WIDTH-1:0] seq,
  input  logic [CNT_W-1:0]               free,
  output logic [PORTS*SEQ_NUM_WIDTH-1:0] slot_data,
  output logic [PORTS-1:0]               accept_mask,
  output logic [LANE_W-1:0]              accept_cnt,
  output logic [LANE_W-1:0]              drop_cnt
);

  logic [LANE_W-1:0] rank;
  logic [LANE_W-1:0] acc;

  // Walk ports in ascending order; a valid port's rank is its slot, and it is kept only while rank < free.
  always_comb begin
    rank        = '0;
    acc         = '0;
    accept_mask = '0;
    slot_data   = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (valid[i]) begin
        if (CNT_W'(rank) < free) begin
          accept_mask[i] = 1'b1;
          slot_data[int'(rank)*SEQ_NUM_WIDTH +: SEQ_NUM_WIDTH] = seq[i*SEQ_NUM_WIDTH +: SEQ_NUM_WIDTH];
          acc = acc + LANE_W'(1);
        end
        rank = rank + LANE_W'(1);
      end
    end
    accept_cnt = acc;
    drop_cnt   = rank - acc;
  end

endmodule

// File: rtl/pcie_us_rq_seq_num_merge.sv
// Merges N per-cycle RQ sequence-number report ports from the PCIe core into
// one ordered valid/ready stream, with a circular buffer, registered
// show-ahead output and a saturating count of reports lost to overflow.
module pcie_us_rq_seq_num_merge
  import pcie_us_rq_seq_num_merge_pkg::*;
#(
  parameter int SEQ_NUM_WIDTH  = 6,
  parameter int PORTS          = 2,
  parameter int DEPTH          = 16,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORTS*SEQ_NUM_WIDTH-1:0]   s_axis_rq_seq_num,
  input  logic [PORTS-1:0]                 s_axis_rq_seq_num_valid,
  output logic [SEQ_NUM_WIDTH-1:0]         m_axis_rq_seq_num,
  output logic                             m_axis_rq_seq_num_valid,
  input  logic                             m_axis_rq_seq_num_ready,
  output logic [$clog2(DEPTH):0]           status_count,
  output logic                             status_overflow,
  output logic [DROP_CNT_WIDTH-1:0]        status_drop_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = lane_width(PORTS);
  localparam int DSUM_W = DROP_CNT_WIDTH + 1;

  logic [SEQ_NUM_WIDTH-1:0]       mem_q [DEPTH];
  logic [SEQ_NUM_WIDTH-1:0]       mem_d [DEPTH];
  logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           m_valid_q, m_valid_d;
  logic [SEQ_NUM_WIDTH-1:0]       m_seq_q, m_seq_d;
  logic                           overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0]      drop_q, drop_d;

  logic [CNT_W-1:0]               free;
  logic                           pop;
  logic [PORTS*SEQ_NUM_WIDTH-1:0] slot_data;
  logic [PORTS-1:0]               accept_mask;
  logic [LANE_W-1:0]              accept_cnt;
  logic [LANE_W-1:0]              drop_cnt;
  logic [DSUM_W-1:0]              drop_sum;

  // Space is judged on the registered count only; a same-cycle pop does not make room.
  assign free = CNT_W'(DEPTH) - count_q;

  pcie_us_rq_seq_num_compact #(
    .SEQ_NUM_WIDTH (SEQ_NUM_WIDTH),
    .PORTS         (PORTS),
    .CNT_W         (CNT_W)
  ) u_compact (
    .valid       (s_axis_rq_seq_num_valid),
    .seq         (s_axis_rq_seq_num),
    .free        (free),
    .slot_data   (slot_data),
    .accept_mask (accept_mask),
    .accept_cnt  (accept_cnt),
    .drop_cnt    (drop_cnt)
  );

  // Next-state: write accepted slots at consecutive positions, advance pointers, and preload the next head.
  always_comb begin
    pop   = m_valid_q & m_axis_rq_seq_num_ready;
    mem_d = mem_q;
    for (int j = 0; j < PORTS; j++) begin
      if (LANE_W'(j) < accept_cnt) begin
        mem_d[wr_ptr_q + PTR_W'(j)] = slot_data[j*SEQ_NUM_WIDTH +: SEQ_NUM_WIDTH];
      end
    end
    wr_ptr_d   = wr_ptr_q + PTR_W'(accept_cnt);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(accept_cnt) - CNT_W'(pop);
    m_valid_d  = (count_d != '0);
    m_seq_d    = m_valid_d ? mem_d[rd_ptr_d] : m_seq_q;
    overflow_d = |(s_axis_rq_seq_num_valid & ~accept_mask);
    drop_sum   = {1'b0, drop_q} + DSUM_W'(drop_cnt);
    drop_d     = drop_sum[DSUM_W-1] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
  end

  // Buffer storage needs no reset: pointers and count decide what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control, output and status registers with synchronous reset that discards all buffered entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      m_valid_q  <= 1'b0;
      m_seq_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      m_valid_q  <= m_valid_d;
      m_seq_q    <= m_seq_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign m_axis_rq_seq_num       = m_seq_q;
  assign m_axis_rq_seq_num_valid = m_valid_q;
  assign status_count            = count_q;
  assign status_overflow         = overflow_q;
  assign status_drop_count       = drop_q;

endmodule

// File: tb/tb_pcie_us_rq_seq_num_merge.sv
// Self-checking bench: a queue of expected sequence numbers is filled as
// reports are driven and drained as the DUT hands entries to the consumer.
module tb_pcie_us_rq_seq_num_merge;

  localparam int W     = 6;
  localparam int PORTS = 2;
  localparam int DEPTH = 16;
  localparam int DCW   = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [PORTS*W-1:0] s_seq;
  logic [PORTS-1:0]   s_valid;
  logic [W-1:0]       m_seq;
  logic               m_valid;
  logic               m_ready;
  logic [CW-1:0]      st_count;
  logic               st_ovf;
  logic [DCW-1:0]     st_drop;

  logic [PORTS*W-1:0] sat_seq;
  logic [PORTS-1:0]   sat_valid;
  logic [W-1:0]       sat_m_seq;
  logic               sat_m_valid;
  logic               sat_ready;
  logic [CW-1:0]      sat_count;
  logic               sat_ovf;
  logic [3:0]         sat_drop;

  int n_compared   = 0;
  int n_mismatched = 0;
  int exp_q[$];
  int m_count = 0;
  int m_ovf   = 0;

  pcie_us_rq_seq_num_merge #(
    .SEQ_NUM_WIDTH(W), .PORTS(PORTS), .DEPTH(DEPTH), .DROP_CNT_WIDTH(DCW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_rq_seq_num(s_seq), .s_axis_rq_seq_num_valid(s_valid),
    .m_axis_rq_seq_num(m_seq), .m_axis_rq_seq_num_valid(m_valid),
    .m_axis_rq_seq_num_ready(m_ready),
    .status_count(st_count), .status_overflow(st_ovf), .status_drop_count(st_drop)
  );

  pcie_us_rq_seq_num_merge #(
    .SEQ_NUM_WIDTH(W), .PORTS(PORTS), .DEPTH(DEPTH), .DROP_CNT_WIDTH(4)
  ) dut_sat (
    .clk(clk), .rst(rst),
    .s_axis_rq_seq_num(sat_seq), .s_axis_rq_seq_num_valid(sat_valid),
    .m_axis_rq_seq_num(sat_m_seq), .m_axis_rq_seq_num_valid(sat_m_valid),
    .m_axis_rq_seq_num_ready(sat_ready),
    .status_count(sat_count), .status_overflow(sat_ovf), .status_drop_count(sat_drop)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard: every handshake must deliver the oldest outstanding expected value
  always @(negedge clk) begin
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("[TB] FAIL unexpected_pop: got %0d, required no output", m_seq);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (m_seq !== W'(e)) begin
          n_mismatched++;
          $display("[TB] FAIL pop_order: got %0d, required %0d", m_seq, e);
        end
      end
    end
  end

  // One clock of stimulus on the main DUT with a reference model of acceptance
  task automatic cycle(input logic [1:0] v, input int s0, input int s1, input logic rdy);
    int free, acc, pop, dropped;
    s_valid = v;
    s_seq   = {W'(s1), W'(s0)};
    m_ready = rdy;
    free    = DEPTH - m_count;
    acc     = 0;
    dropped = 0;
    pop     = (m_count > 0 && rdy) ? 1 : 0;
    if (v[0]) begin
      if (acc < free) begin exp_q.push_back(s0); acc++; end else dropped++;
    end
    if (v[1]) begin
      if (acc < free) begin exp_q.push_back(s1); acc++; end else dropped++;
    end
    @(posedge clk);
    #1;
    m_count = m_count + acc - pop;
    m_ovf   = (dropped > 0) ? 1 : 0;
    s_valid = '0;
  endtask

  // Hold ready high until the expected queue empties or the budget runs out
  task automatic drain(input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < budget) begin
      cycle(2'b00, 0, 0, 1'b1);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_compared += 5;
    if (m_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid: got %0b, required 0", m_valid); end
    if (m_seq !== '0) begin n_mismatched++; $display("[TB] FAIL reset_seq: got %0d, required 0", m_seq); end
    if (st_count !== '0) begin n_mismatched++; $display("[TB] FAIL reset_count: got %0d, required 0", st_count); end
    if (st_ovf !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_overflow: got %0b, required 0", st_ovf); end
    if (st_drop !== '0) begin n_mismatched++; $display("[TB] FAIL reset_drop: got %0d, required 0", st_drop); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    cycle(2'b01, 5, 0, 1'b1);
    n_compared += 4;
    if (m_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_valid: got %0b, required 1", m_valid); end
    if (m_seq !== 6'd5) begin n_mismatched++; $display("[TB] FAIL single_seq: got %0d, required 5", m_seq); end
    if (st_count !== CW'(1)) begin n_mismatched++; $display("[TB] FAIL single_count: got %0d, required 1", st_count); end
    if (st_ovf !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_overflow: got %0b, required 0", st_ovf); end
    cycle(2'b00, 0, 0, 1'b1);
    n_compared += 2;
    if (st_count !== '0) begin n_mismatched++; $display("[TB] FAIL single_count_after: got %0d, required 0", st_count); end
    if (m_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_empty: got %0b, required 0", m_valid); end
  endtask

  task automatic test_dual();
    cycle(2'b11, 3, 4, 1'b1);
    n_compared += 2;
    if (st_count !== CW'(2)) begin n_mismatched++; $display("[TB] FAIL dual_count2: got %0d, required 2", st_count); end
    if (m_seq !== 6'd3) begin n_mismatched++; $display("[TB] FAIL dual_head3: got %0d, required 3", m_seq); end
    cycle(2'b00, 0, 0, 1'b1);
    n_compared += 2;
    if (st_count !== CW'(1)) begin n_mismatched++; $display("[TB] FAIL dual_count1: got %0d, required 1", st_count); end
    if (m_seq !== 6'd4) begin n_mismatched++; $display("[TB] FAIL dual_head4: got %0d, required 4", m_seq); end
    cycle(2'b00, 0, 0, 1'b1);
    n_compared++;
    if (st_count !== '0) begin n_mismatched++; $display("[TB] FAIL dual_count0: got %0d, required 0", st_count); end
  endtask

  task automatic test_port_order();
    cycle(2'b10, 0, 9, 1'b1);
    n_compared++;
    if (m_seq !== 6'd9) begin n_mismatched++; $display("[TB] FAIL order_head9: got %0d, required 9", m_seq); end
    cycle(2'b01, 10, 0, 1'b1);
    n_compared += 2;
    if (m_seq !== 6'd10) begin n_mismatched++; $display("[TB] FAIL order_head10: got %0d, required 10", m_seq); end
    if (st_count !== CW'(1)) begin n_mismatched++; $display("[TB] FAIL order_count: got %0d, required 1", st_count); end
    cycle(2'b00, 0, 0, 1'b1);
  endtask

  task automatic test_fill_overflow();
    int n;
    for (int k = 0; k < 8; k++) cycle(2'b11, 20 + 2*k, 21 + 2*k, 1'b0);
    n_compared += 2;
    if (st_count !== CW'(16)) begin n_mismatched++; $display("[TB] FAIL fill_count: got %0d, required 16", st_count); end
    if (m_seq !== 6'd20) begin n_mismatched++; $display("[TB] FAIL fill_head: got %0d, required 20", m_seq); end
    cycle(2'b11, 50, 51, 1'b0);
    n_compared += 3;
    if (st_ovf !== 1'(m_ovf)) begin n_mismatched++; $display("[TB] FAIL full_overflow: got %0b, required %0d", st_ovf, m_ovf); end
    if (st_drop !== DCW'(2)) begin n_mismatched++; $display("[TB] FAIL full_drop: got %0d, required 2", st_drop); end
    if (st_count !== CW'(16)) begin n_mismatched++; $display("[TB] FAIL full_count: got %0d, required 16", st_count); end
    cycle(2'b00, 0, 0, 1'b0);
    n_compared++;
    if (st_ovf !== 1'b0) begin n_mismatched++; $display("[TB] FAIL overflow_pulse: got %0b, required 0", st_ovf); end
    drain(40, n);
    n_compared += 2;
    if (n != 16 || exp_q.size() != 0) begin n_mismatched++; $display("[TB] FAIL fill_drain_cycles: got %0d, required 16", n); end
    if (st_count !== '0) begin n_mismatched++; $display("[TB] FAIL fill_drain_count: got %0d, required 0", st_count); end
  endtask

  task automatic test_free_one();
    int n;
    for (int k = 0; k < 7; k++) cycle(2'b11, 30 + 2*k, 31 + 2*k, 1'b0);
    cycle(2'b01, 44, 0, 1'b0);
    n_compared++;
    if (st_count !== CW'(15)) begin n_mismatched++; $display("[TB] FAIL free1_count15: got %0d, required 15", st_count); end
    cycle(2'b11, 1, 2, 1'b1);
    n_compared += 3;
    if (st_ovf !== 1'b1) begin n_mismatched++; $display("[TB] FAIL free1_overflow: got %0b, required 1", st_ovf); end
    if (st_drop !== DCW'(3)) begin n_mismatched++; $display("[TB] FAIL free1_drop: got %0d, required 3", st_drop); end
    if (st_count !== CW'(m_count)) begin n_mismatched++; $display("[TB] FAIL free1_count: got %0d, required %0d", st_count, m_count); end
    drain(40, n);
    n_compared++;
    if (n != 15 || exp_q.size() != 0) begin n_mismatched++; $display("[TB] FAIL free1_drain_cycles: got %0d, required 15", n); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) cycle(2'b11, 40 + 2*k, 41 + 2*k, 1'b0);
    cycle(2'b01, 46, 0, 1'b0);
    n_compared++;
    if (st_count !== CW'(7)) begin n_mismatched++; $display("[TB] FAIL mid_count7: got %0d, required 7", st_count); end
    rst     = 1'b1;
    s_valid = 2'b11;
    s_seq   = {W'(60), W'(61)};
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    s_valid = '0;
    exp_q.delete();
    m_count = 0;
    n_compared += 4;
    if (m_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_valid: got %0b, required 0", m_valid); end
    if (st_count !== '0) begin n_mismatched++; $display("[TB] FAIL mid_count: got %0d, required 0", st_count); end
    if (st_drop !== '0) begin n_mismatched++; $display("[TB] FAIL mid_drop: got %0d, required 0", st_drop); end
    if (st_ovf !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_overflow: got %0b, required 0", st_ovf); end
    cycle(2'b01, 12, 0, 1'b1);
    n_compared += 2;
    if (m_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_after_valid: got %0b, required 1", m_valid); end
    if (m_seq !== 6'd12) begin n_mismatched++; $display("[TB] FAIL mid_after_seq: got %0d, required 12", m_seq); end
    cycle(2'b00, 0, 0, 1'b1);
    n_compared++;
    if (exp_q.size() != 0) begin n_mismatched++; $display("[TB] FAIL mid_after_pop: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_saturation();
    int expd;
    sat_ready = 1'b0;
    for (int k = 0; k < 18; k++) begin
      sat_valid = 2'b11;
      sat_seq   = {W'(k), W'(k + 32)};
      @(posedge clk);
      #1;
      expd = (k < 8) ? 0 : ((2 * (k - 7) > 15) ? 15 : 2 * (k - 7));
      if (k == 7 || k == 14 || k == 15 || k == 17) begin
        n_compared++;
        if (sat_drop !== 4'(expd)) begin n_mismatched++; $display("[TB] FAIL sat_drop_k%0d: got %0d, required %0d", k, sat_drop, expd); end
      end
    end
    sat_valid = '0;
    n_compared += 2;
    if (sat_count !== CW'(16)) begin n_mismatched++; $display("[TB] FAIL sat_count: got %0d, required 16", sat_count); end
    if (sat_ovf !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sat_overflow: got %0b, required 1", sat_ovf); end
  endtask

  // Run every scenario in order, then report
  initial begin
    rst       = 1'b1;
    s_valid   = '0;
    s_seq     = '0;
    m_ready   = 1'b0;
    sat_valid = '0;
    sat_seq   = '0;
    sat_ready = 1'b0;
    test_reset();
    test_single();
    test_dual();
    test_port_order();
    test_fill_overflow();
    test_free_one();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
